serial_comparator_ctrl: RTL and testbench

Sequencer that compares two WIDTH-bit unsigned words one bit per cycle, MSB first, using the team's 1-bit comparator slice. The slice's 3-bit result encoding is c[2]=a>b, c[1]=a==b, c[0]=a<b. The block captures operands on a start request, walks the bits, and stops at the first differing bit. It reports a one-hot 3-bit result with a done pulse. It sits between a requesting datapath and the single-bit compare resource, so multi-bit comparisons reuse one slice instead of WIDTH slices.

---
 rtl/serial_comparator_ctrl_if.sv | 18 +
 rtl/serial_comparator_ctrl.sv | 79 +++++++
 tb/tb_serial_comparator_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_ctrl_if.sv
// Request/response bundle between a datapath requester and the serial comparator.
// The master side raises start with operands; the slave side reports busy/done/result.
interface serial_comparator_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [2:0]       c;
    logic [CW-1:0]    count;

    modport master (output start, a, b, input busy, done, c, count);
    modport slave  (input start, a, b, output busy, done, c, count);
endinterface

// File: rtl/serial_comparator_ctrl.sv
// MSB-first bit-serial magnitude comparator built around one 1-bit compare slice.
// Stops at the first differing bit and reports a one-hot {gt,eq,lt} with a done pulse.
module serial_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_comparator_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    n;
    logic [2:0]       c_q;
    logic [CW-1:0]    count_q;

    // 1-bit comparator slice, encoding {a>b, a==b, a<b}
    logic       a_msb;
    logic       b_msb;
    logic [2:0] slice;

    assign a_msb = a_sr[WIDTH-1];
    assign b_msb = b_sr[WIDTH-1];
    assign slice = {a_msb & ~b_msb, ~(a_msb ^ b_msb), ~a_msb & b_msb};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            n       <= '0;
            c_q     <= 3'b000;
            count_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        n     <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    n <= n + CW'(1);
                    if (slice[2] || slice[0]) begin
                        c_q     <= slice;
                        count_q <= n + CW'(1);
                        state   <= S_DONE;
                    end else if (n == CW'(WIDTH - 1)) begin
                        c_q     <= 3'b010;
                        count_q <= CW'(WIDTH);
                        state   <= S_DONE;
                    end else begin
                        a_sr <= a_sr << 1;
                        b_sr <= b_sr << 1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                // Unused encoding recovers to IDLE instead of locking up
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status decoded from state only; no combinational path from start/a/b
    assign bus.busy  = (state == S_RUN);
    assign bus.done  = (state == S_DONE);
    assign bus.c     = c_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Scoreboard bench: the driver pushes model results at each accepted start; an
// independent negedge monitor checks busy, done timing, c and count against them.
module tb_serial_comparator_ctrl;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        int         k;
        int         n;
        logic [2:0] c;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    int   next_ok;
    int   last_k;
    int   last_c;
    int   last_count;
    exp_t q[$];

    serial_comparator_ctrl_if #(.WIDTH(W)) bus ();

    serial_comparator_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: compare as integers, run length from the highest differing bit
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [2:0] c, output int n);
        logic [W-1:0] diff;
        if (av > bv)      c = 3'b100;
        else if (av < bv) c = 3'b001;
        else              c = 3'b010;
        diff = av ^ bv;
        n = W;
        for (int i = 0; i < W; i++)
            if (diff[i]) n = W - i;
    endfunction

    // mode 0: quiet wait; 1: scramble a/b/start while busy; 2: start held high
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input int mode);
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc + 1 >= next_ok) break;
            if (mode == 1) begin
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.start = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.start = 1'b1;
            end
        end
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        model(av, bv, e.c, e.n);
        e.k     = cyc + 1;
        last_k  = e.k;
        next_ok = e.k + e.n + 2;
        q.push_back(e);
        @(negedge clk);
        if (mode != 2) bus.start = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        last_c     = 0;
        last_count = 0;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        bit   exp_busy;
        if (rst) begin
            check("rst_busy", int'(bus.busy), 0);
            check("rst_done", int'(bus.done), 0);
            check("rst_c", int'(bus.c), 0);
            check("rst_count", int'(bus.count), 0);
        end else begin
            exp_busy = (q.size() > 0) && (cyc >= q[0].k) && (cyc < q[0].k + q[0].n);
            check("busy", int'(bus.busy), int'(exp_busy));
            if (bus.done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.k + e.n);
                    check("c", int'(bus.c), int'(e.c));
                    check("count", int'(bus.count), e.n);
                    last_c     = int'(e.c);
                    last_count = e.n;
                end
            end else begin
                if (q.size() > 0 && cyc >= q[0].k + q[0].n) begin
                    e = q.pop_front();
                    check("missed_done", 0, 1);
                    last_c     = int'(e.c);
                    last_count = e.n;
                end
                check("c_hold", int'(bus.c), last_c);
                check("count_hold", int'(bus.count), last_count);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        total      = 0;
        bad        = 0;
        next_ok    = 0;
        last_k     = 0;
        last_c     = 0;
        last_count = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        next_ok = cyc + 1;

        // Directed cases: equal, MSB decides, LSB decides, mid bit decides
        launch(8'hA5, 8'hA5, 0);
        launch(8'h80, 8'h7F, 0);
        launch(8'h12, 8'h13, 0);
        launch(8'h3C, 8'h34, 0);

        // Operand/start noise while an operation is in flight
        launch(8'h5A, 8'h5B, 0);
        launch(8'hC3, 8'hC3, 1);
        launch(8'h01, 8'h02, 1);

        // start held high continuously
        for (int i = 0; i < 5; i++) launch(W'($urandom), W'($urandom), 2);
        bus.start = 1'b0;

        // Randomized, biased towards near-equal operands
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = W'($urandom);
                1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = ra;
            endcase
            launch(ra, rb, int'($urandom_range(0, 1)));
        end

        // Reset during RUN: no done, outputs return to reset values at once
        launch(8'h01, 8'h00, 0);
        while (cyc < last_k + 3) @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_busy", int'(bus.busy), 0);
        check("async_done", int'(bus.done), 0);
        check("async_c", int'(bus.c), 0);
        check("async_count", int'(bus.count), 0);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        next_ok = cyc + 1;
        launch(8'h01, 8'h00, 0);

        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", q.size(), 0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
